bft_leaf_tx_port: RTL and testbench

Transmit endpoint for one output stream into the BFT network. Accepts a 32-bit valid/ack user stream, wraps each word in a 49-bit BFT packet addressed to a destination leaf/port, and enforces credit-based flow control against the receiving leaf's input BRAM. Credits are replenished by freespace-update packets arriving from the network. This block is the sending peer of the receive path inside the leaf interface.

---
 rtl/bft_pkg.sv | 46 ++++
 rtl/bft_skid_buf.sv | 63 ++++++
 rtl/bft_leaf_tx_port.sv | 117 +++++++++++
 tb/tb_bft_leaf_tx_port.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// Shared BFT packet definitions: field positions, packet struct, formatter and
// the transmit-port state encoding.
package bft_pkg;

    localparam int BFT_PACKET_BITS   = 49;
    localparam int BFT_PAYLOAD_BITS  = 32;
    localparam int BFT_NUM_LEAF_BITS = 5;
    localparam int BFT_NUM_PORT_BITS = 4;
    localparam int BFT_NUM_ADDR_BITS = 7;

    localparam int BFT_VALID_BIT   = 48;
    localparam int BFT_LEAF_LSB    = 43;
    localparam int BFT_PORT_LSB    = 39;
    localparam int BFT_ADDR_LSB    = 32;
    localparam int BFT_PAYLOAD_LSB = 0;

    typedef struct packed {
        logic                         valid;
        logic [BFT_NUM_LEAF_BITS-1:0] leaf;
        logic [BFT_NUM_PORT_BITS-1:0] port;
        logic [BFT_NUM_ADDR_BITS-1:0] addr;
        logic [BFT_PAYLOAD_BITS-1:0]  payload;
    } bft_pkt_t;

    // Transmit-port status; STALL_RESEND outranks STALL_CREDIT.
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_SEND         = 2'd1;
    localparam logic [1:0] ST_STALL_CREDIT = 2'd2;
    localparam logic [1:0] ST_STALL_RESEND = 2'd3;

    function automatic bft_pkt_t make_packet(
        input logic [BFT_NUM_LEAF_BITS-1:0] leaf,
        input logic [BFT_NUM_PORT_BITS-1:0] port,
        input logic [BFT_NUM_ADDR_BITS-1:0] addr,
        input logic [BFT_PAYLOAD_BITS-1:0]  payload
    );
        bft_pkt_t pkt;
        pkt.valid   = 1'b1;
        pkt.leaf    = leaf;
        pkt.port    = port;
        pkt.addr    = addr;
        pkt.payload = payload;
        return pkt;
    endfunction

endpackage

// File: rtl/bft_skid_buf.sv
// Two-entry buffer for the user front end. in_ready is a flop, so the
// upstream ack never depends combinationally on in_valid.
module bft_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_pop
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             push;
    logic             pop;

    assign push      = in_valid & ready_q;
    assign pop       = out_pop & (cnt_q != 2'd0);
    assign in_ready  = ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
        ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

endmodule

// File: rtl/bft_leaf_tx_port.sv
// BFT transmit endpoint: wraps user words into addressed packets and spends
// receiver-BRAM credits, which are returned by freespace-update packets.
module bft_leaf_tx_port
    import bft_pkg::*;
#(
    parameter int PACKET_BITS   = BFT_PACKET_BITS,
    parameter int PAYLOAD_BITS  = BFT_PAYLOAD_BITS,
    parameter int NUM_LEAF_BITS = BFT_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS = BFT_NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS = BFT_NUM_ADDR_BITS,
    parameter int SRC_PORT      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic [PAYLOAD_BITS-1:0]  din_user,
    input  logic                     vld_user,
    output logic                     ack_user,
    input  logic [PACKET_BITS-1:0]   din_bft,
    output logic [PACKET_BITS-1:0]   dout_bft,
    input  logic                     resend,
    output logic                     credit_err
);

    localparam int CW = NUM_ADDR_BITS + 1;
    localparam int SW = NUM_ADDR_BITS + 3;
    localparam logic [CW-1:0]            CREDIT_MAX   = CW'(1) << NUM_ADDR_BITS;
    localparam logic [SW-1:0]            CREDIT_MAX_S = SW'(1) << NUM_ADDR_BITS;
    localparam logic [NUM_PORT_BITS-1:0] SRC_PORT_L   = NUM_PORT_BITS'(SRC_PORT);

    logic [PAYLOAD_BITS-1:0]  head_data;
    logic                     head_valid;
    logic [1:0]               state_c;
    logic                     send_c;
    logic                     ret_hit_c;
    logic [CW-1:0]            ret_c;
    logic [SW-1:0]            credit_sum_c;

    logic [CW-1:0]            credit_q, credit_d;
    logic [NUM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic                     err_q, err_d;

    // Only the valid bit, port field and credit amount of incoming packets matter.
    logic unused_din;
    assign unused_din = ^{din_bft[PACKET_BITS-2:BFT_PORT_LSB+NUM_PORT_BITS],
                          din_bft[BFT_PORT_LSB-1:CW]};

    bft_skid_buf #(
        .WIDTH(PAYLOAD_BITS)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_data  (din_user),
        .in_valid (vld_user),
        .in_ready (ack_user),
        .out_data (head_data),
        .out_valid(head_valid),
        .out_pop  (send_c)
    );

    always_comb begin
        state_c = ST_SEND;
        if (!head_valid) begin
            state_c = ST_IDLE;
        end else if (resend) begin
            state_c = ST_STALL_RESEND;
        end else if (credit_q == '0) begin
            state_c = ST_STALL_CREDIT;
        end
    end

    assign send_c = (state_c == ST_SEND);

    assign ret_hit_c = din_bft[BFT_VALID_BIT] &&
                       (din_bft[BFT_PORT_LSB +: NUM_PORT_BITS] == SRC_PORT_L);
    assign ret_c     = ret_hit_c ? din_bft[CW-1:0] : '0;

    // Sum is two bits wider than the counter so an overflowing return is visible.
    always_comb begin
        credit_sum_c = SW'(credit_q) - SW'(send_c) + SW'(ret_c);
        credit_d     = credit_sum_c[CW-1:0];
        err_d        = err_q;
        if (credit_sum_c > CREDIT_MAX_S) begin
            credit_d = CREDIT_MAX;
            err_d    = 1'b1;
        end
    end

    always_comb begin
        wr_addr_d = wr_addr_q;
        dout_d    = '0;
        if (send_c) begin
            dout_d    = make_packet(dest_leaf, dest_port, wr_addr_q, head_data);
            wr_addr_d = wr_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q  <= CREDIT_MAX;
            wr_addr_q <= '0;
            dout_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            credit_q  <= credit_d;
            wr_addr_q <= wr_addr_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
        end
    end

    assign dout_bft   = dout_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_bft_leaf_tx_port.sv
// Bench for bft_leaf_tx_port: expected packets queued at user accept and
// compared in order as they appear on dout_bft.
module tb_bft_leaf_tx_port;

    localparam int SRC_PORT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  dest_leaf;
    logic [3:0]  dest_port;
    logic [31:0] din_user;
    logic        vld_user;
    logic        ack_user;
    logic [48:0] din_bft;
    logic [48:0] dout_bft;
    logic        resend;
    logic        credit_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          sent_cnt = 0;
    int          base;
    logic [48:0] exp_q[$];
    logic [6:0]  tb_addr;

    bft_leaf_tx_port #(.SRC_PORT(SRC_PORT)) dut (
        .clk       (clk),
        .reset     (reset),
        .dest_leaf (dest_leaf),
        .dest_port (dest_port),
        .din_user  (din_user),
        .vld_user  (vld_user),
        .ack_user  (ack_user),
        .din_bft   (din_bft),
        .dout_bft  (dout_bft),
        .resend    (resend),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Output monitor: every valid packet must match the oldest expected entry.
    always @(negedge clk) begin
        if (dout_bft[48] === 1'b1) begin
            sent_cnt++;
            if (exp_q.size() == 0) check("unexpected_pkt", 64'(dout_bft), 64'd0);
            else check("pkt", 64'(dout_bft), 64'(exp_q.pop_front()));
        end
    end

    task automatic do_reset();
        bit seen;
        reset    = 1'b1;
        vld_user = 1'b0;
        din_user = '0;
        din_bft  = '0;
        resend   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 64'(dout_bft), 64'd0);
        check("rst_ack", 64'(ack_user), 64'd0);
        check("rst_err", 64'(credit_err), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        tb_addr = '0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ack_user) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ack_after_reset", 64'(seen), 64'd1);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push_word(input logic [31:0] w);
        bit got;
        got      = 1'b0;
        vld_user = 1'b1;
        din_user = w;
        for (int n = 0; n < 20; n++) begin
            if (ack_user) begin
                got = 1'b1;
                exp_q.push_back({1'b1, dest_leaf, dest_port, tb_addr, w});
                tb_addr = tb_addr + 7'd1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        vld_user = 1'b0;
        if (!got) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) push_word($urandom_range(32'hFFFF_FFFF, 0));
    endtask

    task automatic inject(input logic vld, input logic [3:0] port, input logic [31:0] amount);
        din_bft = {vld, 5'd0, port, 7'd0, amount};
        @(negedge clk);
        din_bft = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dest_leaf = 5'd3;
        dest_port = 4'd2;
        do_reset();

        // Single word latency and return to idle
        push_word(32'hDEADBEEF);
        @(negedge clk);
        check("t1_pkt", 64'(dout_bft), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
        @(negedge clk);
        check("t1_idle", 64'(dout_bft), 64'd0);

        // Exhaust all 128 credits
        do_reset();
        base = sent_cnt;
        stream(130);
        repeat (4) @(negedge clk);
        check("t2_sent", 64'(sent_cnt - base), 64'd128);
        check("t2_ack_low", 64'(ack_user), 64'd0);
        check("t2_dout_idle", 64'(dout_bft), 64'd0);
        check("t2_pending", 64'(exp_q.size()), 64'd2);

        // Credit return of 64 resumes sending, address wraps to 0
        base = sent_cnt;
        inject(1'b1, 4'(SRC_PORT), 32'd64);
        check("t3_not_early", 64'(dout_bft[48]), 64'd0);
        @(negedge clk);
        check("t3_resume", 64'(dout_bft[48]), 64'd1);
        check("t3_wrap_addr", 64'(dout_bft[38:32]), 64'd0);
        stream(64);
        repeat (4) @(negedge clk);
        check("t3_sent", 64'(sent_cnt - base), 64'd64);
        check("t3_ack_low", 64'(ack_user), 64'd0);
        check("t3_pending", 64'(exp_q.size()), 64'd2);

        // Foreign-port and invalid credit packets are ignored
        base = sent_cnt;
        inject(1'b1, 4'(SRC_PORT + 1), 32'd64);
        inject(1'b0, 4'(SRC_PORT), 32'd64);
        repeat (5) @(negedge clk);
        check("t4_no_send", 64'(sent_cnt - base), 64'd0);
        check("t4_dout_idle", 64'(dout_bft), 64'd0);

        // Reset with buffered words discards them
        base = sent_cnt;
        do_reset();
        repeat (5) @(negedge clk);
        check("rst_discard", 64'(sent_cnt - base), 64'd0);

        // Resend for 5 cycles in the middle of a stream
        base = sent_cnt;
        fork
            stream(20);
            begin
                repeat (6) @(negedge clk);
                resend = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("t5_resend_quiet", 64'(dout_bft), 64'd0);
                end
                resend = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("t5_sent", 64'(sent_cnt - base), 64'd20);
        check("t5_drained", 64'(exp_q.size()), 64'd0);

        // Overflowing credit return clamps and sets the sticky error
        do_reset();
        inject(1'b1, 4'(SRC_PORT), 32'd10);
        check("t6_err_set", 64'(credit_err), 64'd1);
        base = sent_cnt;
        stream(130);
        repeat (4) @(negedge clk);
        check("t6_clamped_sent", 64'(sent_cnt - base), 64'd128);
        check("t6_err_sticky", 64'(credit_err), 64'd1);
        do_reset();
        check("t6_err_cleared", 64'(credit_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
